// File: rtl/seg7_display_drv_pkg.sv
// Shared constants for the seg7_display_drv block.
// Contents:
//   NUM_DIGITS - number of multiplexed digits on the display
//   SEG_OFF    - segment pattern with every segment dark (active-low)
//   AN_OFF     - anode pattern with every digit dark (active-low)
//   SEG_LUT    - hex nibble to {g,f,e,d,c,b,a} pattern, active-low
package seg7_display_drv_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [6:0]  SEG_OFF    = 7'h7F;
   localparam logic [3:0]  AN_OFF     = 4'hF;

   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_display_drv_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to 7-segment decode.
// Ports:
//   i_nibble - 4-bit hex digit
//   o_seg    - {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
   import seg7_display_drv_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_LUT[i_nibble];
   end

endmodule

// File: rtl/seg7_display_drv.sv
// seg7_display_drv: latches a 16-bit word and scans it as four hex digits
// onto a common-anode, time-multiplexed 7-segment display.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   value - word to display (two's complement accumulator)
//   load  - capture value into the display latch at this edge
//   blank - force all anodes off; scanning keeps running
//   an    - anode enables, active-low, an[0] = rightmost digit
//   seg   - segments {g,f,e,d,c,b,a}, active-low
//   dp    - decimal point, active-low, lit on digit 3 for negative values
// Parameters:
//   REFRESH_DIV - clk cycles each digit stays lit (>= 1)
//   CNT_W       - refresh counter width, 2**CNT_W >= REFRESH_DIV
// Build option:
//   LEADING_ZERO_BLANK_EN - when defined, leading zero digits 3..1 are dark
module seg7_display_drv
   import seg7_display_drv_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned CNT_W       = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_digit;
   logic [15:0]      r_latch;

   logic [3:0]       w_nibble;
   logic [6:0]       w_seg;
   logic [3:0]       w_an;
   logic             w_dp;
   logic             w_suppress;

   assign w_nibble = r_latch[{r_digit, 2'b00} +: 4];

   hex_to_seg7 u_hex_to_seg7 (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows.
   always_comb begin
      w_suppress = 1'b0;
      case (r_digit)
         2'd3:    w_suppress = (r_latch[15:12] == '0);
         2'd2:    w_suppress = (r_latch[15:8]  == '0);
         2'd1:    w_suppress = (r_latch[15:4]  == '0);
         default: w_suppress = 1'b0;
      endcase
   end
`else
   assign w_suppress = 1'b0;
`endif

   always_comb begin
      w_an = AN_OFF;
      if (!(blank || w_suppress)) begin
         w_an[r_digit] = 1'b0;
      end
   end

   assign w_dp = ~(r_latch[15] && (r_digit == 2'd3) && !blank && !w_suppress);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_digit <= '0;
         r_latch <= '0;
         an      <= AN_OFF;
         seg     <= SEG_OFF;
         dp      <= 1'b1;
      end else begin
         if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_digit <= r_digit + 2'd1;
         end else begin
            r_cnt   <= r_cnt + 1'b1;
         end
         if (load) begin
            r_latch <= value;
         end
         an  <= w_an;
         seg <= w_seg;
         dp  <= w_dp;
      end
   end

endmodule

// File: tb/tb_seg7_display_drv.sv
module tb_seg7_display_drv;

   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic        load;
   logic        blank;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   seg7_display_drv #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .value (value),
      .load  (load),
      .blank (blank),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   always #5 clk = ~clk;

   logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int checks = 0;
   int errors = 0;

   // Reference model: number of clock edges since reset release and latch contents.
   int          m_tick;
   logic [15:0] m_latch;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;

   task automatic model_reset();
      m_tick  = 0;
      m_latch = 16'h0000;
   endtask

   // Drive one cycle and compute what the outputs must be after its rising edge.
   task automatic tick(input logic ld, input logic [15:0] v, input logic bl);
      int d;
      int nib;
      bit sup;
      @(negedge clk);
      load  = ld;
      value = v;
      blank = bl;
      d   = (m_tick / RD) % 4;
      nib = int'(m_latch >> (4 * d)) % 16;
      sup = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      sup = (d > 0) && ((m_latch >> (4 * d)) == 16'h0000);
`endif
      e_an = 4'hF;
      if (!(bl || sup)) e_an[d] = 1'b0;
      e_seg = lut[nib];
      e_dp  = !(m_latch[15] && d == 3 && !bl && !sup);
      if (ld) m_latch = v;
      m_tick++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; blank = 1'b0; value = 16'h0000;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      tick(1'b1, 16'hBEEF, 1'b0);
      repeat (6) tick(1'b0, 16'h0000, 1'b0);
      // Asynchronous assertion away from any clock edge.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
         errors++;
         $display("FAIL reset_async: an=%b seg=%h dp=%b, required an=1111 seg=7f dp=1", an, seg, dp);
      end
      @(posedge clk);
      #2 rst = 1'b0; load = 1'b0;
      model_reset();
      tick(1'b0, 16'h0000, 1'b0);
      checks++;
      if (an !== 4'b1110 || seg !== 7'h40 || dp !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: an=%b seg=%h dp=%b, required an=1110 seg=40 dp=1", an, seg, dp);
      end
   endtask

   task automatic test_scan(input logic [15:0] v, input int cycles);
      tick(1'b1, v, 1'b0);
      for (int i = 0; i < cycles; i++) begin
         tick(1'b0, 16'h0000, 1'b0);
         checks++;
         if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
            errors++;
            $display("FAIL scan_%h cyc %0d: an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                     v, i, an, seg, dp, e_an, e_seg, e_dp);
         end
      end
   endtask

   task automatic test_sign();
      int dp_low = 0;
      tick(1'b1, 16'h8000, 1'b0);
      for (int i = 0; i < 4 * RD + 4; i++) begin
         tick(1'b0, 16'h0000, 1'b0);
         if (dp === 1'b0) dp_low++;
         checks++;
         if (dp !== e_dp || (dp === 1'b0 && (an !== 4'b0111 || seg !== 7'h00))) begin
            errors++;
            $display("FAIL sign_dp cyc %0d: an=%b seg=%h dp=%b, required dp=%b (dp low only with an=0111 seg=00)",
                     i, an, seg, dp, e_dp);
         end
      end
      checks++;
      if (dp_low != RD) begin
         errors++;
         $display("FAIL sign_dp_count: dp low %0d cycles, required %0d", dp_low, RD);
      end
   endtask

   task automatic test_blank();
      int guard = 0;
      tick(1'b1, 16'hFFFF, 1'b0);
      // Advance to the last cycle in which digit 1 is driving the outputs.
      while (!(((m_tick / RD) % 4 == 1) && (m_tick % RD == RD - 1)) && guard < 100) begin
         tick(1'b0, 16'h0000, 1'b0);
         guard++;
      end
      checks++;
      if (guard >= 100) begin
         errors++;
         $display("FAIL blank_align: no alignment after %0d cycles, required < 100", guard);
      end
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 16'h0000, 1'b1);
         checks++;
         if (an !== 4'hF || seg !== e_seg || dp !== e_dp) begin
            errors++;
            $display("FAIL blank_hold cyc %0d: an=%b seg=%h dp=%b, required an=1111 seg=%h dp=%b",
                     i, an, seg, dp, e_seg, e_dp);
         end
      end
      tick(1'b0, 16'h0000, 1'b0);
      checks++;
      if (an !== 4'b0111 || seg !== 7'h0E || dp !== 1'b0) begin
         errors++;
         $display("FAIL blank_release: an=%b seg=%h dp=%b, required an=0111 seg=0e dp=0", an, seg, dp);
      end
   endtask

   task automatic test_reset_load();
      @(negedge clk);
      rst = 1'b1; load = 1'b1; value = 16'hFFFF;
      @(posedge clk);
      #2 rst = 1'b0; load = 1'b0;
      model_reset();
      tick(1'b0, 16'h0000, 1'b0);
      checks++;
      if (an !== 4'b1110 || seg !== 7'h40) begin
         errors++;
         $display("FAIL reset_over_load: an=%b seg=%h, required an=1110 seg=40", an, seg);
      end
   endtask

   task automatic test_back_to_back();
      tick(1'b1, 16'h1234, 1'b0);
      tick(1'b1, 16'hC5D6, 1'b0);
      for (int i = 0; i < 4 * RD; i++) begin
         tick(1'b0, 16'h0000, 1'b0);
         checks++;
         if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
            errors++;
            $display("FAIL back_to_back cyc %0d: an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                     i, an, seg, dp, e_an, e_seg, e_dp);
         end
      end
   endtask

   task automatic test_random();
      logic        ld;
      logic        bl;
      logic [15:0] v;
      for (int i = 0; i < 400; i++) begin
         ld = ($urandom_range(3) == 0);
         bl = ($urandom_range(6) == 0);
         case ($urandom_range(3))
            0:       v = 16'($urandom_range(255));
            1:       v = 16'h8000 | 16'($urandom);
            default: v = 16'($urandom);
         endcase
         tick(ld, v, bl);
         checks++;
         if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
            errors++;
            $display("FAIL random cyc %0d: an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                     i, an, seg, dp, e_an, e_seg, e_dp);
         end
      end
   endtask

`ifdef LEADING_ZERO_BLANK_EN
   task automatic test_leading_zero();
      bit hi_lit;
      bit seen1;
      bit seen0;
      hi_lit = 1'b0; seen1 = 1'b0; seen0 = 1'b0;
      tick(1'b1, 16'h0042, 1'b0);
      for (int i = 0; i < 4 * RD + 4; i++) begin
         tick(1'b0, 16'h0000, 1'b0);
         if (an[3] === 1'b0 || an[2] === 1'b0) hi_lit = 1'b1;
         if (an === 4'b1101 && seg === 7'h19) seen1 = 1'b1;
         if (an === 4'b1110 && seg === 7'h24) seen0 = 1'b1;
      end
      checks++;
      if (hi_lit || !seen1 || !seen0) begin
         errors++;
         $display("FAIL lzb_0042: hi_lit=%b seen_d1=%b seen_d0=%b, required 0 1 1", hi_lit, seen1, seen0);
      end
      tick(1'b1, 16'h0000, 1'b0);
      for (int i = 0; i < 4 * RD + 4; i++) begin
         tick(1'b0, 16'h0000, 1'b0);
         checks++;
         if (an !== e_an || (an[3:1] !== 3'b111) || (an[0] === 1'b0 && seg !== 7'h40)) begin
            errors++;
            $display("FAIL lzb_zero cyc %0d: an=%b seg=%h, required an=%b (only an[0], seg=40)",
                     i, an, seg, e_an);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan(16'h1A2F, 4 * RD * 2 + 2);
      test_sign();
      test_blank();
      test_reset_load();
      test_back_to_back();
`ifdef LEADING_ZERO_BLANK_EN
      test_leading_zero();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
